// File: rtl/fifo_write_packer.sv
// Packs RATIO narrow upstream words into one FIFO-width word (lane 0 in the LSBs)
// and feeds the FIFO write port through an output register backed by a skid register.
module fifo_write_packer #(
    parameter int DELAY     = 1,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 128,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 wren,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 flush,
    output logic                 full,
    output logic                 overflow,
    output logic                 busy,
    output logic                 fifo_wren,
    output logic [OUT_WIDTH-1:0] fifo_din,
    input  logic                 fifo_full,
    output logic [CNT_WIDTH-1:0] word_count
);

    localparam int RATIO  = OUT_WIDTH / IN_WIDTH;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    generate
        if (RATIO < 1 || RATIO > 16 || RATIO * IN_WIDTH != OUT_WIDTH || DELAY < 0) begin : g_bad_params
            $error("fifo_write_packer: OUT_WIDTH must be 1..16 times IN_WIDTH");
        end
    endgenerate

    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [OUT_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic                 accept;
    logic                 pop;
    logic                 complete;
    logic [OUT_WIDTH-1:0] merged;

    always_comb begin
        // full is skid_valid_q, so an accepted write always has a free slot to land in
        accept       = wren && !skid_valid_q;
        pop          = out_valid_q && !fifo_full;
        merged       = acc_q;
        if (accept) begin
            merged[lane_q*IN_WIDTH +: IN_WIDTH] = din;
        end
        complete     = (accept && (lane_q == LAST_LANE)) || (flush && ((lane_q != '0) || accept));

        lane_d       = lane_q;
        acc_d        = merged;
        if (complete) begin
            lane_d = '0;
            acc_d  = '0;
        end else if (accept) begin
            lane_d = lane_q + 1'b1;
        end

        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (pop) begin
            if (skid_valid_q) begin
                out_data_d = skid_data_q;
                if (complete) begin
                    skid_data_d = merged;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (complete) begin
                out_data_d = merged;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (!out_valid_q) begin
            if (complete) begin
                out_valid_d = 1'b1;
                out_data_d  = merged;
            end
        end else if (complete) begin
            skid_valid_d = 1'b1;
            skid_data_d  = merged;
        end

        overflow_d   = overflow_q || (wren && skid_valid_q);
        count_d      = count_q + CNT_WIDTH'(pop);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lane_q       <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            overflow_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            lane_q       <= lane_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            overflow_q   <= overflow_d;
            count_q      <= count_d;
        end
    end

    assign full       = skid_valid_q;
    assign overflow   = overflow_q;
    assign busy       = (lane_q != '0) || out_valid_q || skid_valid_q;
    assign fifo_wren  = pop;
    assign fifo_din   = out_data_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_fifo_write_packer.sv
// Bench for fifo_write_packer: a RATIO=4 instance with a 4-bit counter and a RATIO=1 instance,
// FIFO-side data checked against per-instance expected-word queues.
module tb_fifo_write_packer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RATIO=4 instance
    logic         rstn_a = 1'b1;
    logic         wren_a = 1'b0, flush_a = 1'b0, ffull_a = 1'b0;
    logic [31:0]  din_a = '0;
    logic         full_a, ovf_a, busy_a, fwren_a;
    logic [127:0] fdin_a;
    logic [3:0]   wc_a;

    // RATIO=1 instance
    logic         rstn_b = 1'b1;
    logic         wren_b = 1'b0, flush_b = 1'b0, ffull_b = 1'b0;
    logic [31:0]  din_b = '0;
    logic         full_b, ovf_b, busy_b, fwren_b;
    logic [31:0]  fdin_b;
    logic [31:0]  wc_b;

    fifo_write_packer #(.DELAY(1), .IN_WIDTH(32), .OUT_WIDTH(128), .CNT_WIDTH(4)) u_a (
        .CLK(CLK), .RESET_N(rstn_a), .wren(wren_a), .din(din_a), .flush(flush_a),
        .full(full_a), .overflow(ovf_a), .busy(busy_a), .fifo_wren(fwren_a),
        .fifo_din(fdin_a), .fifo_full(ffull_a), .word_count(wc_a)
    );

    fifo_write_packer #(.DELAY(1), .IN_WIDTH(32), .OUT_WIDTH(32), .CNT_WIDTH(32)) u_b (
        .CLK(CLK), .RESET_N(rstn_b), .wren(wren_b), .din(din_b), .flush(flush_b),
        .full(full_b), .overflow(ovf_b), .busy(busy_b), .fifo_wren(fwren_b),
        .fifo_din(fdin_b), .fifo_full(ffull_b), .word_count(wc_b)
    );

    int checks = 0;
    int errors = 0;
    int pops_a = 0;
    int pops_b = 0;
    logic [127:0] q_a[$];
    logic [127:0] q_b[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // FIFO-side monitors: a write happens at the next posedge when fifo_wren is high now
    always @(negedge CLK) begin
        if (rstn_a && fwren_a) begin
            pops_a++;
            if (q_a.size() == 0) chk("a_unexpected_write", fdin_a, 128'hx);
            else chk("a_fifo_din", fdin_a, q_a.pop_front());
        end
        if (rstn_b && fwren_b) begin
            pops_b++;
            if (q_b.size() == 0) chk("b_unexpected_write", 128'(fdin_b), 128'hx);
            else chk("b_fifo_din", 128'(fdin_b), q_b.pop_front());
        end
    end

    task automatic step_a(input logic w, input logic [31:0] d, input logic f);
        wren_a = w; din_a = d; flush_a = f;
        @(posedge CLK); #1;
    endtask

    task automatic step_b(input logic w, input logic [31:0] d);
        wren_b = w; din_b = d;
        @(posedge CLK); #1;
    endtask

    typedef struct {
        logic         w;
        logic [31:0]  d;
        logic         f;
        logic         e_full;
        logic         e_busy;
        logic         e_fwren;
        logic [3:0]   e_wc;
        logic         push;
        logic [127:0] word;
    } vec_t;

    localparam int NV = 18;
    vec_t vec[NV];

    initial begin
        logic [31:0] r0, r1, r2, r3;

        vec[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 128'h0};
        vec[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 128'h0};
        vec[2]  = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 128'h0};
        vec[3]  = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1,
                    128'h00000044_00000033_00000022_00000011};
        vec[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 128'h0};
        vec[5]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 128'h0};
        vec[6]  = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 128'h0};
        vec[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1,
                    128'h00000000_00000000_0000000B_0000000A};
        vec[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 128'h0};
        vec[9]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 128'h0};
        vec[10] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 128'h0};
        vec[11] = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1,
                    128'h00000000_00000033_00000022_00000011};
        vec[12] = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 128'h0};
        vec[13] = '{1'b1, 32'h66, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 128'h0};
        vec[14] = '{1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 128'h0};
        vec[15] = '{1'b1, 32'h88, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1,
                    128'h00000088_00000077_00000066_00000055};
        vec[16] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 128'h0};
        vec[17] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 128'h0};

        // reset state
        #2 rstn_a = 1'b0; rstn_b = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_full",     128'(full_a),  128'd0);
        chk("rst_overflow", 128'(ovf_a),   128'd0);
        chk("rst_busy",     128'(busy_a),  128'd0);
        chk("rst_fwren",    128'(fwren_a), 128'd0);
        chk("rst_fdin",     fdin_a,        128'd0);
        chk("rst_wc",       128'(wc_a),    128'd0);
        chk("rst_b_wc",     128'(wc_b),    128'd0);
        rstn_a = 1'b1; rstn_b = 1'b1;
        @(posedge CLK); #1;

        // RATIO=4 vector table
        for (int i = 0; i < NV; i++) begin
            if (vec[i].push) q_a.push_back(vec[i].word);
            step_a(vec[i].w, vec[i].d, vec[i].f);
            chk($sformatf("v%0d_full", i),  128'(full_a),  128'(vec[i].e_full));
            chk($sformatf("v%0d_busy", i),  128'(busy_a),  128'(vec[i].e_busy));
            chk($sformatf("v%0d_fwren", i), 128'(fwren_a), 128'(vec[i].e_fwren));
            chk($sformatf("v%0d_wc", i),    128'(wc_a),    128'(vec[i].e_wc));
        end
        chk("a_overflow_clear", 128'(ovf_a), 128'd0);

        // RATIO=1: blocked FIFO, skid fill, overflow, then drain in order
        ffull_b = 1'b1;
        q_b.push_back(128'h1);
        step_b(1'b1, 32'h1);
        chk("b_full_after1", 128'(full_b),  128'd0);
        chk("b_busy_after1", 128'(busy_b),  128'd1);
        q_b.push_back(128'h2);
        step_b(1'b1, 32'h2);
        chk("b_full_after2", 128'(full_b),  128'd1);
        step_b(1'b1, 32'h3);
        chk("b_overflow",    128'(ovf_b),   128'd1);
        chk("b_full_hold",   128'(full_b),  128'd1);
        step_b(1'b0, 32'h0);
        step_b(1'b0, 32'h0);
        chk("b_full_held",   128'(full_b),  128'd1);
        chk("b_fwren_held",  128'(fwren_b), 128'd0);
        ffull_b = 1'b0;
        #1 chk("b_fwren_release", 128'(fwren_b), 128'd1);
        step_b(1'b0, 32'h0);
        chk("b_full_fall",   128'(full_b),  128'd0);
        chk("b_wc1",         128'(wc_b),    128'd1);
        step_b(1'b0, 32'h0);
        chk("b_wc2",         128'(wc_b),    128'd2);
        chk("b_busy_idle",   128'(busy_b),  128'd0);
        chk("b_ovf_sticky",  128'(ovf_b),   128'd1);

        // RATIO=1 sustained throughput
        for (int i = 0; i < 5; i++) begin
            q_b.push_back(128'(32'h100 + i));
            step_b(1'b1, 32'h100 + i);
            chk($sformatf("b_tp%0d_fwren", i), 128'(fwren_b), 128'd1);
            chk($sformatf("b_tp%0d_full", i),  128'(full_b),  128'd0);
        end
        step_b(1'b0, 32'h0);
        chk("b_tp_wc",       128'(wc_b),    128'd7);

        // RATIO=4: fill out and skid with FIFO blocked, reject one write, reset mid-cycle
        ffull_a = 1'b1;
        for (int i = 0; i < 8; i++) step_a(1'b1, 32'h200 + i, 1'b0);
        chk("a_full_skid",   128'(full_a),  128'd1);
        step_a(1'b1, 32'h999, 1'b0);
        chk("a_overflow",    128'(ovf_a),   128'd1);
        chk("a_busy_pend",   128'(busy_a),  128'd1);
        wren_a = 1'b0;
        #2 rstn_a = 1'b0;
        #1;
        chk("mrst_full",     128'(full_a),  128'd0);
        chk("mrst_overflow", 128'(ovf_a),   128'd0);
        chk("mrst_busy",     128'(busy_a),  128'd0);
        chk("mrst_fwren",    128'(fwren_a), 128'd0);
        chk("mrst_fdin",     fdin_a,        128'd0);
        chk("mrst_wc",       128'(wc_a),    128'd0);
        ffull_a = 1'b0;
        @(posedge CLK); #1;
        rstn_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_a(1'b0, 32'h0, 1'b0);
            chk($sformatf("post_rst%0d_fwren", i), 128'(fwren_a), 128'd0);
        end

        // one clean word, then 16 more to wrap the 4-bit counter
        q_a.push_back(128'h000000A4_000000A3_000000A2_000000A1);
        step_a(1'b1, 32'hA1, 1'b0);
        step_a(1'b1, 32'hA2, 1'b0);
        step_a(1'b1, 32'hA3, 1'b0);
        step_a(1'b1, 32'hA4, 1'b0);
        step_a(1'b0, 32'h0, 1'b0);
        chk("clean_wc",      128'(wc_a),    128'd1);
        chk("clean_busy",    128'(busy_a),  128'd0);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("wrap_wc15", 128'(wc_a), 128'd15);
            r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
            q_a.push_back({r3, r2, r1, r0});
            step_a(1'b1, r0, 1'b0);
            step_a(1'b1, r1, 1'b0);
            step_a(1'b1, r2, 1'b0);
            step_a(1'b1, r3, 1'b0);
        end
        step_a(1'b0, 32'h0, 1'b0);
        chk("wrap_wc",       128'(wc_a),    128'd1);

        repeat (3) step_a(1'b0, 32'h0, 1'b0);
        chk("a_queue_empty", 128'(q_a.size()), 128'd0);
        chk("b_queue_empty", 128'(q_b.size()), 128'd0);
        chk("a_pop_count",   128'(pops_a),     128'd21);
        chk("b_pop_count",   128'(pops_b),     128'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
